// File: rtl/rapcore_harness.sv
// -----------------------------------------------------------------------------
// rapcore_harness
// Board-level stimulus and plant model for the rapcores motor-controller pins.
//   * SPI master (mode 0, MSB first) that plays a fixed script of 64-bit
//     command words once after reset, then parks in RUN.
//   * Step/dir/enable source: ENINPUT from the start of the post-reset wait,
//     and a free-running STEPINPUT square wave with DIRINPUT=1 once in RUN.
//   * Quadrature encoder model that follows STEPOUTPUT/DIROUTPUT.
//   * Two current comparators that compare coil drive time against the
//     reference PWM over fixed measurement windows.
// Ports
//   CLK, RESET                      clock, synchronous active-high reset
//   SCK, CS, COPI / CIPO            SPI master outputs / SPI data from the core
//   STEPINPUT, DIRINPUT, ENINPUT,
//   HALT                            motion inputs to the core (HALT held low)
//   STEPOUTPUT, DIROUTPUT, ENOUTPUT motion outputs from the core
//   ENC_A, ENC_B                    encoder model outputs
//   analog_out1/2 / analog_cmp1/2   reference PWM in / comparator model out
//   PHASE_*                         bridge gate drives
//   CHARGEPUMP, BUFFER_DTR,
//   MOVE_DONE                       status inputs, monitored only
// -----------------------------------------------------------------------------
module rapcore_harness #(
    parameter int SPI_DIV     = 4,
    parameter int START_DELAY = 1000,
    parameter int WORD_GAP    = 32,
    parameter int NUM_CMDS    = 4,
    parameter int STEP_PERIOD = 200,
    parameter int WIN         = 256
) (
    input  logic CLK,
    input  logic RESET,
    output logic SCK,
    output logic CS,
    output logic COPI,
    input  logic CIPO,
    output logic STEPINPUT,
    output logic DIRINPUT,
    output logic ENINPUT,
    output logic HALT,
    input  logic STEPOUTPUT,
    input  logic DIROUTPUT,
    input  logic ENOUTPUT,
    output logic ENC_A,
    output logic ENC_B,
    input  logic analog_out1,
    input  logic analog_out2,
    output logic analog_cmp1,
    output logic analog_cmp2,
    input  logic PHASE_A1,
    input  logic PHASE_A2,
    input  logic PHASE_B1,
    input  logic PHASE_B2,
    input  logic PHASE_A1_H,
    input  logic PHASE_A2_H,
    input  logic PHASE_B1_H,
    input  logic PHASE_B2_H,
    input  logic CHARGEPUMP,
    input  logic BUFFER_DTR,
    input  logic MOVE_DONE
);

    localparam logic [63:0] CMD0 = 64'h0A00_0000_0000_0001;  // enable
    localparam logic [63:0] CMD1 = 64'h1000_0000_0000_0040;  // current
    localparam logic [63:0] CMD2 = 64'h0100_0000_0000_0010;  // move
    localparam logic [63:0] CMD3 = 64'h0000_0000_0000_0000;  // nop

    localparam logic [8:0] WIN_SAT = 9'(WIN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4,
        ST_RUN   = 3'd5
    } state_t;

    // Command script ROM
    function automatic logic [63:0] cmd_rom(input logic [7:0] idx);
        logic [63:0] word;
        case (idx)
            8'd0:    word = CMD0;
            8'd1:    word = CMD1;
            8'd2:    word = CMD2;
            8'd3:    word = CMD3;
            default: word = 64'h0000_0000_0000_0000;
        endcase
        return word;
    endfunction

    // One quadrature step along 00->01->11->10->00 (up) or the reverse (down)
    function automatic logic [1:0] gray_step(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        case (cur)
            2'b00:   nxt = up ? 2'b01 : 2'b10;
            2'b01:   nxt = up ? 2'b11 : 2'b00;
            2'b11:   nxt = up ? 2'b10 : 2'b01;
            2'b10:   nxt = up ? 2'b00 : 2'b11;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    // Increment a window counter by one sample, holding at the window length
    function automatic logic [8:0] sat_inc(input logic [8:0] cnt, input logic inc);
        logic [8:0] res;
        if (inc && (cnt < WIN_SAT)) begin
            res = cnt + 9'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------ state
    state_t      state_r;
    logic        cs_r, sck_r, en_r, step_r, dir_r, halt_r;
    logic [15:0] cnt_r;        // WAIT / GAP / RUN half-period counter
    logic [15:0] div_cnt_r;    // SCK half-period divider
    logic [6:0]  bit_cnt_r;    // SCK rising edges in the current word
    logic [7:0]  word_idx_r;
    logic [63:0] tx_shift_r;   // bit 63 is the bit currently on COPI
    logic [63:0] rx_shift_r;
    logic [63:0] rx_last_r;
    logic [63:0] cmd_word_s;

    logic [2:0]  step_sync_r;  // [0],[1] synchroniser, [2] edge-detect history
    logic [1:0]  dir_sync_r;
    logic [1:0]  enc_r;
    logic        step_rise_s;

    logic [8:0]  win_cnt_r;
    logic [8:0]  ref_a_r, drv_a_r, ref_b_r, drv_b_r;
    logic [8:0]  ref_a_nxt_s, drv_a_nxt_s, ref_b_nxt_s, drv_b_nxt_s;
    logic        drv_a_s, drv_b_s, win_end_s;
    logic        cmp1_r, cmp2_r;

    logic [15:0] done_cnt_r;
    logic        move_done_d_r, mon_dtr_r, mon_cp_r, mon_en_r;
    logic [82:0] monitor_unused_s;

    assign SCK       = sck_r;
    assign CS        = cs_r;
    assign COPI      = tx_shift_r[63];
    assign STEPINPUT = step_r;
    assign DIRINPUT  = dir_r;
    assign ENINPUT   = en_r;
    assign HALT      = halt_r;
    assign ENC_A     = enc_r[1];
    assign ENC_B     = enc_r[0];
    assign analog_cmp1 = cmp1_r;
    assign analog_cmp2 = cmp2_r;

    // Debug/monitor state gathered into one bundle; nothing downstream consumes it
    assign monitor_unused_s = {rx_last_r, done_cnt_r, mon_dtr_r, mon_cp_r, mon_en_r};

    // Combinational helpers: current script word, step edge, window accumulation
    always_comb begin
        cmd_word_s  = cmd_rom(word_idx_r);
        step_rise_s = step_sync_r[1] & ~step_sync_r[2];
        // A coil is driven when one low side and the opposite high side are both on
        drv_a_s     = (PHASE_A1 & PHASE_A2_H) | (PHASE_A2 & PHASE_A1_H);
        drv_b_s     = (PHASE_B1 & PHASE_B2_H) | (PHASE_B2 & PHASE_B1_H);
        ref_a_nxt_s = sat_inc(ref_a_r, analog_out1);
        drv_a_nxt_s = sat_inc(drv_a_r, drv_a_s);
        ref_b_nxt_s = sat_inc(ref_b_r, analog_out2);
        drv_b_nxt_s = sat_inc(drv_b_r, drv_b_s);
        win_end_s   = (win_cnt_r == 9'(WIN - 1));
    end

    // Script sequencer: SPI master and step/dir/enable generation
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            cs_r       <= 1'b1;
            sck_r      <= 1'b0;
            en_r       <= 1'b0;
            step_r     <= 1'b0;
            dir_r      <= 1'b0;
            halt_r     <= 1'b0;
            cnt_r      <= 16'd0;
            div_cnt_r  <= 16'd0;
            bit_cnt_r  <= 7'd0;
            word_idx_r <= 8'd0;
            tx_shift_r <= 64'd0;
            rx_shift_r <= 64'd0;
            rx_last_r  <= 64'd0;
        end else begin
            halt_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_WAIT;
                    en_r    <= 1'b1;
                    cnt_r   <= 16'd0;
                end
                ST_WAIT, ST_GAP: begin
                    // WAIT is entered one cycle after release, so it ends two counts early
                    if (((state_r == ST_WAIT) && (cnt_r == 16'(START_DELAY - 2))) ||
                        ((state_r == ST_GAP)  && (cnt_r == 16'(WORD_GAP - 1)))) begin
                        state_r    <= ST_LOAD;
                        cs_r       <= 1'b0;
                        tx_shift_r <= cmd_word_s;
                        cnt_r      <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_LOAD: begin
                    // The LOAD cycle counts as the first cycle before the first SCK rise
                    state_r   <= ST_SHIFT;
                    div_cnt_r <= 16'd1;
                    bit_cnt_r <= 7'd0;
                end
                ST_SHIFT: begin
                    if (div_cnt_r == 16'(SPI_DIV - 1)) begin
                        div_cnt_r <= 16'd0;
                        if (!sck_r) begin
                            sck_r      <= 1'b1;
                            rx_shift_r <= {rx_shift_r[62:0], CIPO};
                            bit_cnt_r  <= bit_cnt_r + 7'd1;
                        end else begin
                            sck_r <= 1'b0;
                            if (bit_cnt_r == 7'd64) begin
                                cs_r       <= 1'b1;
                                tx_shift_r <= 64'd0;
                                rx_last_r  <= rx_shift_r;
                                cnt_r      <= 16'd0;
                                if (word_idx_r == 8'(NUM_CMDS - 1)) begin
                                    state_r <= ST_RUN;
                                    dir_r   <= 1'b1;
                                    step_r  <= 1'b0;
                                end else begin
                                    state_r    <= ST_GAP;
                                    word_idx_r <= word_idx_r + 8'd1;
                                end
                            end else begin
                                tx_shift_r <= {tx_shift_r[62:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'd1;
                    end
                end
                ST_RUN: begin
                    dir_r <= 1'b1;
                    if (cnt_r == 16'(STEP_PERIOD / 2 - 1)) begin
                        cnt_r  <= 16'd0;
                        step_r <= ~step_r;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_r    <= 1'b1;
                    sck_r   <= 1'b0;
                end
            endcase
        end
    end

    // Encoder plant: synchronise step/dir and advance one Gray state per step
    always_ff @(posedge CLK) begin
        if (RESET) begin
            step_sync_r <= 3'b000;
            dir_sync_r  <= 2'b00;
            enc_r       <= 2'b00;
        end else begin
            step_sync_r <= {step_sync_r[1:0], STEPOUTPUT};
            dir_sync_r  <= {dir_sync_r[0], DIROUTPUT};
            if (step_rise_s) begin
                enc_r <= gray_step(enc_r, dir_sync_r[1]);
            end else begin
                enc_r <= enc_r;
            end
        end
    end

    // Comparator plant: accumulate per window, decide and hold at window end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            win_cnt_r <= 9'd0;
            ref_a_r   <= 9'd0;
            drv_a_r   <= 9'd0;
            ref_b_r   <= 9'd0;
            drv_b_r   <= 9'd0;
            cmp1_r    <= 1'b0;
            cmp2_r    <= 1'b0;
        end else if (win_end_s) begin
            cmp1_r    <= (drv_a_nxt_s > ref_a_nxt_s);
            cmp2_r    <= (drv_b_nxt_s > ref_b_nxt_s);
            win_cnt_r <= 9'd0;
            ref_a_r   <= 9'd0;
            drv_a_r   <= 9'd0;
            ref_b_r   <= 9'd0;
            drv_b_r   <= 9'd0;
        end else begin
            win_cnt_r <= win_cnt_r + 9'd1;
            ref_a_r   <= ref_a_nxt_s;
            drv_a_r   <= drv_a_nxt_s;
            ref_b_r   <= ref_b_nxt_s;
            drv_b_r   <= drv_b_nxt_s;
        end
    end

    // Status monitors: MOVE_DONE edge counter and sampled status pins
    always_ff @(posedge CLK) begin
        if (RESET) begin
            done_cnt_r    <= 16'd0;
            move_done_d_r <= 1'b0;
            mon_dtr_r     <= 1'b0;
            mon_cp_r      <= 1'b0;
            mon_en_r      <= 1'b0;
        end else begin
            move_done_d_r <= MOVE_DONE;
            mon_dtr_r     <= BUFFER_DTR;
            mon_cp_r      <= CHARGEPUMP;
            mon_en_r      <= ENOUTPUT;
            if (MOVE_DONE && !move_done_d_r && (done_cnt_r != 16'hFFFF)) begin
                done_cnt_r <= done_cnt_r + 16'd1;
            end else begin
                done_cnt_r <= done_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_rapcore_harness.sv
// -----------------------------------------------------------------------------
// tb_rapcore_harness
// Directed sequence with randomized data (CIPO bits, encoder directions,
// comparator duty) checked against a behavioural model of the harness.
// -----------------------------------------------------------------------------
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_rapcore_harness;

    localparam int SPI_DIV     = 4;
    localparam int START_DELAY = 1000;
    localparam int WORD_GAP    = 32;
    localparam int NUM_CMDS    = 4;
    localparam int STEP_PERIOD = 200;
    localparam int WIN         = 256;

    logic CLK = 1'b0;
    logic RESET;
    logic SCK, CS, COPI, CIPO;
    logic STEPINPUT, DIRINPUT, ENINPUT, HALT;
    logic STEPOUTPUT, DIROUTPUT, ENOUTPUT;
    logic ENC_A, ENC_B;
    logic analog_out1, analog_out2, analog_cmp1, analog_cmp2;
    logic PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2;
    logic PHASE_A1_H, PHASE_A2_H, PHASE_B1_H, PHASE_B2_H;
    logic CHARGEPUMP, BUFFER_DTR, MOVE_DONE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // non-reset clock edges since the last reset

    logic [63:0] cmd_tab [4] = '{64'h0A00_0000_0000_0001, 64'h1000_0000_0000_0040,
                                 64'h0100_0000_0000_0010, 64'h0000_0000_0000_0000};
    logic [1:0]  gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    rapcore_harness #(
        .SPI_DIV(SPI_DIV), .START_DELAY(START_DELAY), .WORD_GAP(WORD_GAP),
        .NUM_CMDS(NUM_CMDS), .STEP_PERIOD(STEP_PERIOD), .WIN(WIN)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .SCK(SCK), .CS(CS), .COPI(COPI), .CIPO(CIPO),
        .STEPINPUT(STEPINPUT), .DIRINPUT(DIRINPUT), .ENINPUT(ENINPUT), .HALT(HALT),
        .STEPOUTPUT(STEPOUTPUT), .DIROUTPUT(DIROUTPUT), .ENOUTPUT(ENOUTPUT),
        .ENC_A(ENC_A), .ENC_B(ENC_B),
        .analog_out1(analog_out1), .analog_out2(analog_out2),
        .analog_cmp1(analog_cmp1), .analog_cmp2(analog_cmp2),
        .PHASE_A1(PHASE_A1), .PHASE_A2(PHASE_A2), .PHASE_B1(PHASE_B1), .PHASE_B2(PHASE_B2),
        .PHASE_A1_H(PHASE_A1_H), .PHASE_A2_H(PHASE_A2_H),
        .PHASE_B1_H(PHASE_B1_H), .PHASE_B2_H(PHASE_B2_H),
        .CHARGEPUMP(CHARGEPUMP), .BUFFER_DTR(BUFFER_DTR), .MOVE_DONE(MOVE_DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Cycles (edges) until CS is seen low; ENINPUT captured after the first edge
    task automatic cs_high_len(input int limit, output int n, output logic en1);
        n = 0;
        en1 = 1'b0;
        while ((CS === 1'b1 || n == 0) && n < limit) begin
            tick();
            n++;
            if (n == 1) en1 = ENINPUT;
        end
    endtask

    // Follow one CS-low word: COPI at each SCK rise, and the CIPO values the DUT sampled
    task automatic capture_word(input logic rand_cipo, output logic [63:0] word,
                                output logic [63:0] rx, output int nbits,
                                output int first_rise, output int bad_per);
        logic prev, cipo_v;
        int t, last;
        word = 64'd0; rx = 64'd0; nbits = 0; first_rise = -1; bad_per = 0;
        prev = SCK; t = 0; last = 0;
        while (CS === 1'b0 && t < 1000) begin
            cipo_v = rand_cipo ? 1'($urandom_range(0, 1)) : 1'b1;
            CIPO = cipo_v;
            tick();
            t++;
            if (SCK === 1'b1 && prev === 1'b0) begin
                word = {word[62:0], COPI};
                rx   = {rx[62:0], cipo_v};
                if (nbits == 0) first_rise = t;
                else if (t - last != 2 * SPI_DIV) bad_per++;
                last = t;
                nbits++;
            end
            prev = SCK;
        end
        CIPO = 1'b1;
    endtask

    task automatic level_len(input logic lvl, input int limit, output int n);
        n = 0;
        while (STEPINPUT === lvl && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic step_pulse(input logic d);
        DIROUTPUT = d;
        STEPOUTPUT = 1'b1;
        repeat (2) tick();
        STEPOUTPUT = 1'b0;
        repeat (4) tick();
    endtask

    // Drive one coil: driven via either diagonal pair, undriven via a same-side pair or idle
    task automatic coil(input logic driven, output logic x1, output logic x2,
                        output logic x1h, output logic x2h);
        logic sel;
        sel = 1'($urandom_range(0, 1));
        if (driven) begin
            x1 = sel; x2h = sel; x2 = ~sel; x1h = ~sel;
        end else begin
            x1 = sel; x1h = sel; x2 = 1'b0; x2h = 1'b0;
        end
    endtask

    task automatic run_window(input int na, input int ma, input int nb, input int mb);
        for (int j = 0; j < WIN; j++) begin
            analog_out1 = (j < na);
            analog_out2 = (j < nb);
            coil(j < ma, PHASE_A1, PHASE_A2, PHASE_A1_H, PHASE_A2_H);
            coil(j < mb, PHASE_B1, PHASE_B2, PHASE_B1_H, PHASE_B2_H);
            tick();
        end
        analog_out1 = 1'b0; analog_out2 = 1'b0;
        {PHASE_A1, PHASE_A2, PHASE_A1_H, PHASE_A2_H} = 4'b0000;
        {PHASE_B1, PHASE_B2, PHASE_B1_H, PHASE_B2_H} = 4'b0000;
    endtask

    initial begin
        int n, nbits, first, badper, pos, k, guard;
        int na, ma, nb, mb;
        logic en1, d;
        logic [63:0] word, rx;

        RESET = 1'b1; CIPO = 1'b1;
        STEPOUTPUT = 1'b0; DIROUTPUT = 1'b0; ENOUTPUT = 1'b0;
        analog_out1 = 1'b0; analog_out2 = 1'b0;
        {PHASE_A1, PHASE_A2, PHASE_A1_H, PHASE_A2_H} = 4'b0000;
        {PHASE_B1, PHASE_B2, PHASE_B1_H, PHASE_B2_H} = 4'b0000;
        CHARGEPUMP = 1'b0; BUFFER_DTR = 1'b0; MOVE_DONE = 1'b0;

        // Reset state
        repeat (3) tick();
        `CHK("rst_cs", CS, 1'b1)
        `CHK("rst_sck", SCK, 1'b0)
        `CHK("rst_copi", COPI, 1'b0)
        `CHK("rst_step", STEPINPUT, 1'b0)
        `CHK("rst_dir", DIRINPUT, 1'b0)
        `CHK("rst_en", ENINPUT, 1'b0)
        `CHK("rst_halt", HALT, 1'b0)
        `CHK("rst_enc", {ENC_A, ENC_B}, 2'b00)
        `CHK("rst_cmp", {analog_cmp1, analog_cmp2}, 2'b00)

        // Start delay and the scripted words
        RESET = 1'b0;
        cs_high_len(START_DELAY + 50, n, en1);
        `CHK("start_delay", n, START_DELAY)
        `CHK("en_cycle1", en1, 1'b1)
        `CHK("halt_wait", HALT, 1'b0)
        for (int w = 0; w < NUM_CMDS; w++) begin
            capture_word(w != 0, word, rx, nbits, first, badper);
            `CHK("word_bits", nbits, 64)
            `CHK("word_copi", word, cmd_tab[w])
            `CHK("first_rise", first, SPI_DIV)
            `CHK("sck_period", badper, 0)
            `CHK("rx_last", dut.rx_last_r, rx)
            if (w == 0) `CHK("rx_last_ones", dut.rx_last_r, 64'hFFFF_FFFF_FFFF_FFFF)
            if (w < NUM_CMDS - 1) begin
                cs_high_len(WORD_GAP + 50, n, en1);
                `CHK("word_gap", n, WORD_GAP)
            end
        end

        // RUN: step waveform starts low, 100 low / 100 high
        `CHK("run_dir", DIRINPUT, 1'b1)
        `CHK("run_step0", STEPINPUT, 1'b0)
        level_len(1'b0, STEP_PERIOD, n);
        `CHK("step_low", n, STEP_PERIOD / 2)
        level_len(1'b1, STEP_PERIOD, n);
        `CHK("step_high", n, STEP_PERIOD / 2)
        level_len(1'b0, STEP_PERIOD, n);
        `CHK("step_low2", n, STEP_PERIOD / 2)
        `CHK("run_cs", CS, 1'b1)
        `CHK("run_halt", HALT, 1'b0)

        // Encoder: three-cycle latency, then directed and random steps
        pos = 0;
        DIROUTPUT = 1'b1; STEPOUTPUT = 1'b1;
        repeat (2) tick();
        `CHK("enc_lat2", {ENC_A, ENC_B}, 2'b00)
        tick();
        pos++;
        `CHK("enc_lat3", {ENC_A, ENC_B}, gray_tab[pos % 4])
        STEPOUTPUT = 1'b0;
        repeat (4) tick();
        for (int i = 1; i < 5; i++) begin
            step_pulse(1'b1);
            pos++;
            `CHK("enc_up", {ENC_A, ENC_B}, gray_tab[pos % 4])
        end
        for (int i = 0; i < 2; i++) begin
            step_pulse(1'b0);
            pos = pos + 3;  // one step down, kept non-negative
            `CHK("enc_down", {ENC_A, ENC_B}, gray_tab[pos % 4])
        end
        for (int i = 0; i < 10; i++) begin
            d = 1'($urandom_range(0, 1));
            step_pulse(d);
            pos = pos + (d ? 1 : 3);
            `CHK("enc_rand", {ENC_A, ENC_B}, gray_tab[pos % 4])
        end

        // Comparators: align to a window boundary, then directed and random duty
        guard = 0;
        while ((cyc % WIN) != 0 && guard < WIN + 5) begin
            tick();
            guard++;
        end
        nb = $urandom_range(0, WIN); mb = $urandom_range(0, WIN);
        run_window(100, 150, nb, mb);
        `CHK("cmp1_gt", analog_cmp1, 1'b1)
        `CHK("cmp2_rand", analog_cmp2, (mb > nb))
        run_window(100, 100, 40, 40);
        `CHK("cmp1_eq", analog_cmp1, 1'b0)
        `CHK("cmp2_eq", analog_cmp2, 1'b0)
        for (int i = 0; i < 4; i++) begin
            na = $urandom_range(0, WIN); ma = $urandom_range(0, WIN);
            nb = $urandom_range(0, WIN); mb = (i == 3) ? nb : $urandom_range(0, WIN);
            run_window(na, ma, nb, mb);
            `CHK("cmp1_rand", analog_cmp1, (ma > na))
            `CHK("cmp2_rand", analog_cmp2, (mb > nb))
        end

        // MOVE_DONE rising edges
        k = $urandom_range(1, 9);
        for (int i = 0; i < k; i++) begin
            MOVE_DONE = 1'b1; tick();
            MOVE_DONE = 1'b0; tick();
        end
        tick();
        `CHK("done_cnt", dut.done_cnt_r, 16'(k))

        // Abort during word 2 and restart the script from CMD0
        RESET = 1'b1; tick(); RESET = 1'b0;
        cs_high_len(START_DELAY + 50, n, en1);
        `CHK("restart_delay", n, START_DELAY)
        for (int w = 0; w < 2; w++) begin
            capture_word(1'b1, word, rx, nbits, first, badper);
            `CHK("rs_word", word, cmd_tab[w])
            cs_high_len(WORD_GAP + 50, n, en1);
            `CHK("rs_gap", n, WORD_GAP)
        end
        k = $urandom_range(20, 400);
        repeat (k) tick();
        `CHK("mid_word_cs", CS, 1'b0)
        RESET = 1'b1;
        tick();
        `CHK("abort_cs", CS, 1'b1)
        `CHK("abort_sck", SCK, 1'b0)
        `CHK("abort_copi", COPI, 1'b0)
        `CHK("abort_en", ENINPUT, 1'b0)
        RESET = 1'b0;
        cs_high_len(START_DELAY + 50, n, en1);
        `CHK("abort_delay", n, START_DELAY)
        `CHK("abort_en1", en1, 1'b1)
        capture_word(1'b0, word, rx, nbits, first, badper);
        `CHK("abort_word0", word, cmd_tab[0])
        `CHK("abort_bits", nbits, 64)

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
